param_counter: RTL and testbench
================================

PARAM_COUNTER -- requirements
Module: param_counter

Interface
REQ-001 Parameter: WIDTH, 16, counter width in bits, legal range 2..32.
REQ-002 Parameter: RESET_VAL, 0, value count takes on reset; must be < 2^WIDTH.
REQ-003 One clock; reset is asynchronous and active-high; ports named clk and reset.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 reset  in  1  asynchronous active-high reset.
REQ-006 en  in  1  count enable; no count change when low, except load.
REQ-007 up  in  1  direction; 1 = increment, 0 = decrement.
REQ-008 load  in  1  synchronous load of load_val.
REQ-009 load_val  in  WIDTH  value written on load.
REQ-010 max_val  in  WIDTH  terminal (modulus - 1) value, sampled every cycle.
REQ-011 sat  in  1  mode; 1 = saturate at bound, 0 = wrap.
REQ-012 clr_ovf  in  1  clears sticky overflow flag.
REQ-013 count  out  WIDTH  registered counter value.
REQ-014 tc  out  1  combinational terminal count: en & up & (count >= max_val), or en & ~up & (count == 0).
REQ-015 wrap  out  1  registered one-cycle pulse after an edge on which a wrap or saturation clip occurred.
REQ-016 ovf  out  1  registered sticky overflow flag.

Function
REQ-017 Priority per edge: load > en; load ignores en, up, sat and max_val.
REQ-018 Load: count <= load_val at next edge, even if load_val > max_val; wrap not pulsed, ovf unchanged.
REQ-019 en=1, up=1, count < max_val: count <= count + 1.
REQ-020 en=1, up=1, count >= max_val: sat=0 -> count <= 0; sat=1 -> count <= max_val; both are terminal events.
REQ-021 en=1, up=0, count > 0: count <= count - 1, including when count > max_val.
REQ-022 en=1, up=0, count == 0: sat=0 -> count <= max_val; sat=1 -> count holds 0; both are terminal events.
REQ-023 Terminal event: wrap = 1 for exactly the following cycle; ovf set.
REQ-024 Continuous saturation holds wrap high for each edge on which the terminal event repeats.
REQ-025 No arithmetic carries past WIDTH bits; max_val = 2^WIDTH-1 gives full binary range.
REQ-026 max_val = 0: up/wrap keeps count at 0 and pulses wrap every enabled edge.
REQ-027 clr_ovf clears ovf at next edge; a simultaneous terminal event wins, so ovf stays 1.
REQ-028 Latency: every registered output reflects inputs sampled at the previous rising edge.

Reset
REQ-029 reset high forces count = RESET_VAL, wrap = 0, ovf = 0 immediately, without waiting for clk.
REQ-030 While reset is high, all inputs are ignored; assertion mid-count discards state with no partial update.
REQ-031 First update after reset is on the first rising edge with reset low; deassertion is synchronised by the integrator.

Configuration
REQ-032 Macro PARAM_COUNTER_CAPTURE_EN, when defined, adds ports capture (in, 1), cap_val (out, WIDTH) and cap_valid (out, 1).
REQ-033 With the macro: capture high at an edge latches count as it stood before that edge into cap_val, and pulses cap_valid for one cycle.
REQ-034 With the macro: capture coinciding with load or a terminal event still latches the pre-edge count; reset clears cap_val and cap_valid to 0.
REQ-035 Without the macro: the capture ports and registers are absent; all other behaviour is identical.

Verification
REQ-036 WIDTH=16, max_val=9, sat=0, up=1, en=1 for 12 edges -> count 0..9,0,1; wrap high for one cycle after the 9->0 edge; ovf=1.
REQ-037 max_val=5, sat=1, up=1 from count=3 for 5 edges -> 4,5,5,5,5; wrap high on 3 cycles; ovf=1.
REQ-038 up=0, sat=0, max_val=7, count=1 -> 0, then 7; load with load_val=200 and en=1 together -> count=200, no wrap.
REQ-039 clr_ovf=1 on the same edge as a terminal event -> ovf stays 1; clr_ovf=1 alone next edge -> ovf=0.
REQ-040 Assert reset between edges at count=0x1234 with RESET_VAL=3 -> count=3, wrap=0, ovf=0 before the next clk edge.
REQ-041 With PARAM_COUNTER_CAPTURE_EN, capture at count=8 on a wrap edge (max_val=8) -> cap_val=8, cap_valid pulse, count=0.

Source files
------------

// File: rtl/param_counter.sv
// ============================================================================
// Module   : param_counter
// Brief    : Up/down modulus counter with load, saturate/wrap mode, terminal
//            count, wrap pulse and sticky overflow. Optional capture port set
//            enabled by macro PARAM_COUNTER_CAPTURE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module param_counter #(
  parameter int WIDTH     = 16,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max_val,
  input  logic             sat,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
`ifdef PARAM_COUNTER_CAPTURE_EN
  input  logic             capture,
  output logic [WIDTH-1:0] cap_val,
  output logic             cap_valid,
`endif
  output logic             ovf
);

  localparam logic [WIDTH-1:0] c_reset_val = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] c_one       = WIDTH'(1);
  localparam logic [WIDTH-1:0] c_zero      = '0;

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;

  assign tc = en & ((up & (count_q >= max_val)) | (~up & (count_q == c_zero)));

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    ovf_d   = ovf_q;
    if (clr_ovf) begin
      ovf_d = 1'b0;
    end
    if (load) begin
      count_d = load_val;
    end else if (en) begin
      if (up) begin
        if (count_q >= max_val) begin
          count_d = sat ? max_val : c_zero;
          wrap_d  = 1'b1;
          ovf_d   = 1'b1;
        end else begin
          count_d = count_q + c_one;
        end
      end else begin
        // Values above max_val still count down normally; only zero is terminal.
        if (count_q == c_zero) begin
          count_d = sat ? c_zero : max_val;
          wrap_d  = 1'b1;
          ovf_d   = 1'b1;
        end else begin
          count_d = count_q - c_one;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= c_reset_val;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign ovf   = ovf_q;

`ifdef PARAM_COUNTER_CAPTURE_EN
  logic [WIDTH-1:0] cap_val_q;
  logic             cap_valid_q;

  // Captures the pre-edge count regardless of load or terminal activity.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_val_q   <= c_zero;
      cap_valid_q <= 1'b0;
    end else begin
      if (capture) begin
        cap_val_q <= count_q;
      end
      cap_valid_q <= capture;
    end
  end

  assign cap_val   = cap_val_q;
  assign cap_valid = cap_valid_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_param_counter.sv
// ============================================================================
// Module   : tb_param_counter
// Brief    : Directed self-checking bench for param_counter (WIDTH=16,
//            RESET_VAL=3); covers capture ports when PARAM_COUNTER_CAPTURE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_param_counter;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             en, up, load, sat, clr_ovf;
  logic [WIDTH-1:0] load_val, max_val;
  logic [WIDTH-1:0] count;
  logic             tc, wrap, ovf;
`ifdef PARAM_COUNTER_CAPTURE_EN
  logic             capture;
  logic [WIDTH-1:0] cap_val;
  logic             cap_valid;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  param_counter #(.WIDTH(WIDTH), .RESET_VAL(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .max_val  (max_val),
    .sat      (sat),
    .clr_ovf  (clr_ovf),
    .count    (count),
    .tc       (tc),
    .wrap     (wrap),
`ifdef PARAM_COUNTER_CAPTURE_EN
    .capture  (capture),
    .cap_val  (cap_val),
    .cap_valid(cap_valid),
`endif
    .ovf      (ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; en = 0; up = 0; load = 0; sat = 0; clr_ovf = 0;
    load_val = '0; max_val = '0;
`ifdef PARAM_COUNTER_CAPTURE_EN
    capture = 1'b0;
`endif
    #2;
    chk("rst_count", count, 3);
    chk("rst_wrap", wrap, 0);
    chk("rst_ovf", ovf, 0);
    reset = 1'b0;

    // load beats en
    load = 1; load_val = 0; en = 1; up = 1; max_val = 9;
    tick();
    chk("load0_count", count, 0);
    chk("load0_wrap", wrap, 0);

    // modulus-10 wrap sequence
    load = 0;
    for (int i = 1; i <= 11; i++) begin
      if (i == 10) chk("tc_at_9", tc, 1);
      tick();
      chk($sformatf("mod10_count_%0d", i), count, i % 10);
      chk($sformatf("mod10_wrap_%0d", i), wrap, (i == 10) ? 1 : 0);
    end
    chk("mod10_ovf", ovf, 1);

    // saturation from 3 with max 5
    load = 1; load_val = 3; max_val = 5; sat = 1;
    tick();
    chk("sat_load", count, 3);
    load = 0;
    tick(); chk("sat_c1", count, 4); chk("sat_w1", wrap, 0);
    tick(); chk("sat_c2", count, 5); chk("sat_w2", wrap, 0);
    tick(); chk("sat_c3", count, 5); chk("sat_w3", wrap, 1);
    tick(); chk("sat_c4", count, 5); chk("sat_w4", wrap, 1);
    clr_ovf = 1;
    tick(); chk("sat_c5", count, 5); chk("sat_w5", wrap, 1);
    chk("clr_vs_term_ovf", ovf, 1);
    en = 0;
    tick();
    chk("clr_ovf", ovf, 0);
    chk("en0_hold", count, 5);
    chk("en0_wrap", wrap, 0);
    clr_ovf = 0;

    // down-count wrap then load with en
    load = 1; load_val = 1;
    tick();
    load = 0; en = 1; up = 0; sat = 0; max_val = 7;
    tick(); chk("dn_c0", count, 0); chk("dn_w0", wrap, 0);
    #1 chk("tc_down_zero", tc, 1);
    tick(); chk("dn_c7", count, 7); chk("dn_w7", wrap, 1); chk("dn_ovf", ovf, 1);
    load = 1; load_val = 200;
    tick(); chk("ld200_count", count, 200); chk("ld200_wrap", wrap, 0);
    chk("ld200_ovf", ovf, 1);
    load = 0;
    tick(); chk("dn_above_max", count, 199);
    up = 1; sat = 1;
    #1 chk("tc_above_max", tc, 1);
    tick(); chk("clip_to_max", count, 7); chk("clip_wrap", wrap, 1);

    // max_val = 0
    max_val = 0; sat = 0;
    tick(); chk("m0_c_a", count, 0); chk("m0_w_a", wrap, 1);
    tick(); chk("m0_c_b", count, 0); chk("m0_w_b", wrap, 1);

    // full binary range
    load = 1; load_val = 16'hFFFF; max_val = 16'hFFFF;
    tick();
    load = 0;
    tick(); chk("full_up_wrap", count, 0); chk("full_up_w", wrap, 1);
    up = 0;
    tick(); chk("full_dn_wrap", count, 16'hFFFF); chk("full_dn_w", wrap, 1);
    up = 1;
    tick(); chk("full_up_again", count, 0);

    // saturate down at zero
    up = 0; sat = 1;
    tick(); chk("satdn_c", count, 0); chk("satdn_w", wrap, 1);

    // asynchronous reset mid-cycle
    load = 1; load_val = 16'h1234;
    tick();
    chk("pre_rst_count", count, 16'h1234);
    chk("pre_rst_ovf", ovf, 1);
    load = 0; en = 1; up = 1; sat = 0; max_val = 16'hFFFF;
    #2 reset = 1'b1;
    #1;
    chk("async_rst_count", count, 3);
    chk("async_rst_wrap", wrap, 0);
    chk("async_rst_ovf", ovf, 0);
    @(posedge clk); #1;
    chk("rst_held_count", count, 3);
    #2 reset = 1'b0;
    tick();
    chk("post_rst_count", count, 4);

`ifdef PARAM_COUNTER_CAPTURE_EN
    chk("cap_valid_idle", cap_valid, 0);
    load = 1; load_val = 8;
    tick();
    load = 0; max_val = 8; capture = 1;
    tick();
    chk("cap_count", count, 0);
    chk("cap_val", cap_val, 8);
    chk("cap_valid", cap_valid, 1);
    chk("cap_wrap", wrap, 1);
    capture = 0;
    tick();
    chk("cap_valid_drop", cap_valid, 0);
    chk("cap_val_hold", cap_val, 8);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
